// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of a byte-wide data-memory port. A 32-bit load or store from
// the MEM stage is broken into four single-byte accesses at base+0..base+3.
// Returned bytes are assembled into a word. busy_o stalls the pipeline while
// a transfer is in flight.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    request handshake (ready only in IDLE)
//   req_write_i            1 = store, 0 = load
//   req_addr_i             word byte address, must be 4-byte aligned
//   req_wdata_i            store data
//   rsp_valid_o            one-cycle completion pulse
//   rsp_err_o              misaligned request, no memory access made
//   rdata_o                load result, held until the next load completes
//   busy_o                 high whenever not IDLE
//   mem_read_o/write_o     byte read / write strobes
//   mem_addr_o, mem_wdata_o byte address and write data
//   mem_rdata_i            byte read data, valid one cycle after mem_read_o
module load_store_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [31:0]       rdata_o,
    output logic              busy_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BASE_W  = ADDR_W - 2;

    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_WR      = 3'd1;
    localparam logic [STATE_W-1:0] S_RD      = 3'd2;
    localparam logic [STATE_W-1:0] S_RD_LAST = 3'd3;
    localparam logic [STATE_W-1:0] S_RESP    = 3'd4;

    // Byte k of a word, honouring the endian rule.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [DATA_W-1:0] w,
                                                    input logic [1:0]        k);
        if (BIG_ENDIAN) begin
            word_byte = w[{~k, 3'b000} +: BYTE_W];
        end else begin
            word_byte = w[{k, 3'b000} +: BYTE_W];
        end
    endfunction

    // Buffer holds bytes in memory order (lane i = byte at base+i).
    function automatic logic [DATA_W-1:0] to_word(input logic [DATA_W-1:0] b);
        if (BIG_ENDIAN) begin
            to_word = {b[7:0], b[15:8], b[23:16], b[31:24]};
        end else begin
            to_word = b;
        end
    endfunction

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  buf_q, buf_d;
    logic [DATA_W-1:0]  rdata_d;
    logic               req_ready_d;
    logic               rsp_valid_d;
    logic               rsp_err_d;
    logic               busy_d;
    logic               mem_read_d;
    logic               mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [BYTE_W-1:0]  mem_wdata_d;

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd0;
            base_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            buf_q       <= '0;
            rdata_o     <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            buf_q       <= buf_d;
            rdata_o     <= rdata_d;
            req_ready_o <= req_ready_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_err_o   <= rsp_err_d;
            busy_o      <= busy_d;
            mem_read_o  <= mem_read_d;
            mem_write_o <= mem_write_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
        end
    end

    // Next state plus the output values to be registered alongside it.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        buf_d   = buf_q;
        rdata_d = rdata_o;

        case (state_q)
            S_IDLE: begin
                // req_ready_o is high throughout IDLE, so valid alone accepts.
                if (req_valid_i) begin
                    base_d  = req_addr_i[ADDR_W-1:2];
                    wdata_d = req_wdata_i;
                    k_d     = 2'd0;
                    err_d   = (req_addr_i[1:0] != 2'b00);
                    if (err_d) begin
                        state_d = S_RESP;
                    end else if (req_write_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                if (k_q == 2'd3) begin
                    state_d = S_RESP;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_RD: begin
                // Data for the previous cycle's read arrives now.
                if (k_q != 2'd0) begin
                    buf_d[{k_q - 2'd1, 3'b000} +: BYTE_W] = mem_rdata_i;
                end
                if (k_q == 2'd3) begin
                    state_d = S_RD_LAST;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_RD_LAST: begin
                buf_d[31:24] = mem_rdata_i;
                rdata_d      = to_word(buf_d);
                state_d      = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_read_d  = (state_d == S_RD);
        mem_write_d = (state_d == S_WR);
        // Aligned base: byte offset simply fills the low two bits.
        mem_addr_d  = (mem_read_d || mem_write_d) ? {base_d, k_d} : '0;
        mem_wdata_d = mem_write_d ? word_byte(wdata_d, k_d) : '0;
        rsp_valid_d = (state_d == S_RESP);
        rsp_err_d   = rsp_valid_d && err_d;
        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
    end

endmodule
